// File: rtl/pipe_stage_ctrl_if.sv
// Valid/ready handshake between producer, pipeline controller and consumer.
// master = the surrounding environment, slave = the controller.
interface pipe_stage_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Valid/ready sequencer for an N-stage dff datapath: per-stage load enables that
// collapse bubbles, plus flush, occupancy tracking and a saturating stall counter.

module pipe_stage_cell (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic up_valid,
  input  logic rdy_dn,
  output logic rdy,
  output logic en,
  output logic v
);
  // A stage can take new data when it is empty or its contents move on this cycle.
  assign rdy = rdy_dn | ~v;
  assign en  = rdy & up_valid & ~flush & ~reset;

  always_ff @(posedge clk) begin
    if (reset || flush) v <= 1'b0;
    else if (rdy)       v <= up_valid;
  end
endmodule

module pipe_stage_ctrl #(
  parameter  int STAGES = 4,
  parameter  int CNT_W  = 16,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stage_ctrl_if.slave   hs,
  input  logic               flush,
  output logic [STAGES-1:0]  stage_en,
  output logic [OCC_W-1:0]   occupancy,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   stall_cnt
);
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   vld_pipe;  // [0] is the upstream valid, [i+1] is stage i
  logic [STAGES:0]   rdy_x;     // [STAGES] is downstream ready, [i] is stage i
  logic              in_fire, out_fire;

  assign vld_pipe        = {vld, hs.in_valid};
  assign rdy_x[STAGES]   = hs.out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_stage_cell u_cell (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (vld_pipe[i]),
      .rdy_dn   (rdy_x[i+1]),
      .rdy      (rdy_x[i]),
      .en       (stage_en[i]),
      .v        (vld[i])
    );
  end

  assign hs.in_ready  = rdy_x[0] & ~flush & ~reset;
  assign hs.out_valid = vld[STAGES-1] & ~flush & ~reset;
  assign in_fire      = hs.in_valid & hs.in_ready;
  assign out_fire     = hs.out_valid & hs.out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) occupancy <= '0;
    else begin
      case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign full  = (occupancy == OCC_W'(STAGES));
  assign empty = (occupancy == '0);

  // Flush suppresses counting but leaves the accumulated value intact.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (vld[STAGES-1] && !hs.out_ready && !flush && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule
